ro_glitch_monitor: RTL

- Multi-channel ring-oscillator frequency monitor for clock-injection detection.
- Enables NUM_CH external ring oscillators and counts their rising edges over a window of clk_i cycles. In calibration it records per-channel reference counts; in monitor mode it compares each window's counts against reference ± tolerance.
- Raises sticky alarms when enough channels deviate.
- Sits beside the core clock tree. RO instances live at top level and feed ro_i.

---
 rtl/ro_glitch_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ro_glitch_monitor.sv
// Multi-channel ring-oscillator frequency monitor: counts RO edges per window,
// calibrates per-channel references, and raises sticky alarms on deviation.
module ro_glitch_monitor #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned TOL_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALARM_MIN   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    calib_i,
    input  logic [WIN_W-1:0]        win_len_i,
    input  logic [TOL_W-1:0]        tol_i,
    input  logic                    alarm_clr_i,
    input  logic [NUM_CH-1:0]       ro_i,
    output logic [NUM_CH-1:0]       ro_en_o,
    output logic [1:0]              state_o,
    output logic                    valid_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH*CNT_W-1:0] ref_o,
    output logic                    cal_err_o,
    output logic [NUM_CH-1:0]       alarm_ch_o,
    output logic                    alarm_o
);
    localparam int unsigned SET_W = $clog2(SYNC_STAGES + 2);
    localparam int unsigned POP_W = $clog2(NUM_CH + 1);
    localparam int unsigned EXT_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CALIB   = 2'd2,
        MONITOR = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]       hist_q;
    logic [NUM_CH-1:0]       rise_c;
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [CNT_W-1:0]        cnt_nxt_c [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] final_c;
    logic [WIN_W-1:0]        win_cnt_q;
    logic [WIN_W-1:0]        win_len_q;
    logic [WIN_W-1:0]        win_len_eff_c;
    logic [SET_W-1:0]        settle_q;
    logic                    in_win_c;
    logic                    last_cyc_c;
    logic                    win_end_c;
    logic                    abort_c;
    logic                    mon_end_c;
    logic                    cal_ok_c;
    logic                    alarm_hit_c;
    logic [NUM_CH-1:0]       oor_c;
    logic [NUM_CH-1:0]       ok_c;
    logic [POP_W-1:0]        oor_cnt_c;

    logic                    valid_q;
    logic [NUM_CH-1:0]       ro_en_q;
    logic [NUM_CH*CNT_W-1:0] count_q;
    logic [NUM_CH*CNT_W-1:0] ref_q;
    logic                    cal_err_q;
    logic [NUM_CH-1:0]       alarm_ch_q;
    logic                    alarm_q;

    // Per-channel synchroniser followed by a history flop for rising-edge detect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= ro_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Saturating count including this cycle's edge, and range check against the reference
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [EXT_W-1:0] ref_x;
        logic [EXT_W-1:0] tol_x;
        logic [EXT_W-1:0] fin_x;
        logic [EXT_W-1:0] sum_x;
        logic [EXT_W-1:0] lo_x;
        logic [EXT_W-1:0] hi_x;

        assign cnt_nxt_c[c] = (rise_c[c] && (cnt_q[c] != CNT_MAX)) ? cnt_q[c] + CNT_W'(1) : cnt_q[c];
        assign final_c[c*CNT_W +: CNT_W] = cnt_nxt_c[c];

        assign ref_x = EXT_W'(ref_q[c*CNT_W +: CNT_W]);
        assign tol_x = EXT_W'(tol_i);
        assign fin_x = EXT_W'(cnt_nxt_c[c]);
        assign sum_x = ref_x + tol_x;
        assign lo_x  = (ref_x > tol_x) ? ref_x - tol_x : '0;
        assign hi_x  = (sum_x > EXT_W'(CNT_MAX)) ? EXT_W'(CNT_MAX) : sum_x;

        assign oor_c[c] = (fin_x < lo_x) || (fin_x > hi_x) || (cnt_nxt_c[c] == CNT_MAX);
        assign ok_c[c]  = (cnt_nxt_c[c] != '0) && (cnt_nxt_c[c] != CNT_MAX);
    end

    always_comb begin
        oor_cnt_c = '0;
        for (int c = 0; c < NUM_CH; c++) oor_cnt_c = oor_cnt_c + POP_W'(oor_c[c]);
    end

    assign alarm_hit_c   = 32'(oor_cnt_c) >= ALARM_MIN;
    assign cal_ok_c      = &ok_c;
    assign in_win_c      = (state_q == CALIB) || (state_q == MONITOR);
    assign win_len_eff_c = (win_len_i < WIN_W'(2)) ? WIN_W'(2) : win_len_i;
    // Length is at least 2, so the window can never end in its cycle 0
    assign last_cyc_c    = (win_cnt_q != '0) && (win_cnt_q == win_len_q - WIN_W'(1));
    assign mon_end_c     = win_end_c && (state_q == MONITOR);

    // Next-state and window-control decode
    always_comb begin
        state_d   = state_q;
        win_end_c = 1'b0;
        abort_c   = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            abort_c = 1'b1;
        end else begin
            case (state_q)
                IDLE:    state_d = SETTLE;
                SETTLE:  if (settle_q == SET_W'(SYNC_STAGES + 1)) state_d = CALIB;
                CALIB: begin
                    if (last_cyc_c) begin
                        win_end_c = 1'b1;
                        if (cal_ok_c) state_d = MONITOR;
                    end
                end
                MONITOR: begin
                    if (calib_i) begin
                        abort_c = 1'b1;
                        state_d = CALIB;
                    end else if (last_cyc_c) begin
                        win_end_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window counters, result registers and sticky alarms
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_q   <= '0;
            win_cnt_q  <= '0;
            win_len_q  <= WIN_W'(2);
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            valid_q    <= 1'b0;
            ro_en_q    <= '0;
            count_q    <= '0;
            ref_q      <= '0;
            cal_err_q  <= 1'b0;
            alarm_ch_q <= '0;
            alarm_q    <= 1'b0;
        end else begin
            settle_q <= (state_q == SETTLE) ? settle_q + SET_W'(1) : '0;
            if (win_cnt_q == '0) win_len_q <= win_len_eff_c;
            if (!in_win_c || abort_c || win_end_c) begin
                win_cnt_q <= '0;
                for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            end else begin
                win_cnt_q <= win_cnt_q + WIN_W'(1);
                for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_nxt_c[c];
            end
            valid_q <= win_end_c;
            if (win_end_c) count_q <= final_c;
            if (win_end_c && (state_q == CALIB)) begin
                cal_err_q <= ~cal_ok_c;
                if (cal_ok_c) ref_q <= final_c;
            end
            // A setting window end wins over a coincident clear
            alarm_ch_q <= (alarm_ch_q & ~{NUM_CH{alarm_clr_i}}) | (mon_end_c ? oor_c : '0);
            alarm_q    <= (alarm_q & ~alarm_clr_i) | (mon_end_c & alarm_hit_c);
            ro_en_q    <= (state_d != IDLE) ? '1 : '0;
        end
    end

    assign state_o    = state_q;
    assign valid_o    = valid_q;
    assign ro_en_o    = ro_en_q;
    assign count_o    = count_q;
    assign ref_o      = ref_q;
    assign cal_err_o  = cal_err_q;
    assign alarm_ch_o = alarm_ch_q;
    assign alarm_o    = alarm_q;

endmodule
